// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types and scan-code constants
package ps2_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Prefix codes consumed by the downstream scan-code decoder
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT0  = 8'hE0;
  localparam logic [7:0] PS2_EXT1  = 8'hE1;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - kbclk synchroniser with run-length glitch filter
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic [RW-1:0]          run_q;
  logic                   fall_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Synchronise the raw line, then flip the level only after a full run of differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      run_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      fall_q <= 1'b0;
      if (sync_bit == level_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        level_q <= ~level_q;
        run_q   <= '0;
        fall_q  <= level_q;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver producing validated scan codes
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                   kbclk_level;
  logic                   fall_strobe;
  logic                   edge_seen;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   data_bit;

  ps2_state_e             state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic [TW-1:0]          tmo_q;
  logic [7:0]             code_q;
  logic                   code_valid_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   busy_q;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (kbclk),
    .level_o (kbclk_level),
    .fall_o  (fall_strobe)
  );

  // The strobe always coincides with a low filtered level; qualifying keeps the two consistent
  assign edge_seen = fall_strobe & ~kbclk_level;
  assign data_bit  = data_sync_q[SYNC_STAGES-1];

  // kbdata is stable around the falling edge, so synchronisation alone suffices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q <= '1;
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kbdata};
    end
  end

  // Frame capture FSM with timeout; outcome pulses land the cycle after the deciding edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        tmo_q <= '0;
        if (edge_seen && !data_bit) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= 3'd0;
          busy_q    <= 1'b1;
        end
      end else if (edge_seen) begin
        // an edge on the terminal count still wins over the timeout
        tmo_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {data_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_q <= data_bit;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (!data_bit) begin
              frame_err_q <= 1'b1;
            end else if ((^shift_q ^ parity_q) != 1'b1) begin
              parity_err_q <= 1'b1;
            end else begin
              code_q       <= shift_q;
              code_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (tmo_q == TMO_LAST) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        frame_err_q <= 1'b1;
        tmo_q       <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard testbench for ps2_frame_rx
module tb_ps2_frame_rx;

  localparam int HP  = 20;
  localparam int TMO = 400;

  localparam logic [2:0] EV_VALID  = 3'b001;
  localparam logic [2:0] EV_PARITY = 3'b010;
  localparam logic [2:0] EV_FRAME  = 3'b100;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       kbclk  = 1'b1;
  logic       kbdata = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ps2_frame_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kbclk      (kbclk),
    .kbdata     (kbdata),
    .code       (code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] c);
    exp_t e;
    e.kind = kind;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    @(negedge clk);
    kbdata = b;
    wait_cyc(HP / 2);
    if (glitch) begin
      kbclk = 1'b0;
      wait_cyc(3);
      kbclk = 1'b1;
      wait_cyc(HP / 2 - 3);
    end else begin
      wait_cyc(HP / 2);
    end
    kbclk = 1'b0;
    wait_cyc(HP);
    kbclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic glitch, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], glitch && (i == 4));
    end
  endtask

  // Monitor: every outcome pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && (code_valid || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%b required=none code=%0h",
                 {frame_err, parity_err, code_valid}, code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_kind", {29'd0, frame_err, parity_err, code_valid}, {29'd0, e.kind});
        chk("event_code", {24'd0, code}, {24'd0, e.code});
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_code", {24'd0, code}, 32'h00);
    chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // 0x1C: three ones, parity 0
    expect_ev(EV_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
    wait_cyc(20);
    chk("f1c_code", {24'd0, code}, 32'h1C);
    chk("f1c_busy", {31'd0, busy}, 32'd0);

    // idle glitch must be ignored
    kbclk = 1'b0;
    wait_cyc(3);
    kbclk = 1'b1;
    wait_cyc(15);
    chk("idle_glitch_busy", {31'd0, busy}, 32'd0);

    // back-to-back 0xF0 (parity 1) then 0x1C
    expect_ev(EV_VALID, 8'hF0);
    expect_ev(EV_VALID, 8'h1C);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
    wait_cyc(20);
    chk("b2b_code", {24'd0, code}, 32'h1C);

    // 0x5A with wrong parity: code holds 0x1C
    expect_ev(EV_PARITY, 8'h1C);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 11);
    wait_cyc(20);
    chk("perr_code", {24'd0, code}, 32'h1C);

    // 0x5A with bad stop bit
    expect_ev(EV_FRAME, 8'h1C);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 11);
    wait_cyc(20);
    chk("ferr_busy", {31'd0, busy}, 32'd0);

    // mid-frame 3-cycle glitch, frame 0x1C still accepted intact
    expect_ev(EV_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11);
    wait_cyc(20);
    chk("glitch_code", {24'd0, code}, 32'h1C);

    // timeout after four bits
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 4);
    wait_cyc(5);
    chk("tmo_busy_mid", {31'd0, busy}, 32'd1);
    expect_ev(EV_FRAME, 8'h1C);
    wait_cyc(TMO + 100);
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    chk("tmo_code", {24'd0, code}, 32'h1C);
    expect_ev(EV_VALID, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 11);
    wait_cyc(20);
    chk("post_tmo_code", {24'd0, code}, 32'h5A);

    // reset after five bits discards the partial frame
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 5);
    wait_cyc(5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_code", {24'd0, code}, 32'h00);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_pulses", {29'd0, frame_err, parity_err, code_valid}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    expect_ev(EV_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
    wait_cyc(30);
    chk("post_rst_code", {24'd0, code}, 32'h1C);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
